deser_rx: RTL
=============

# deser_rx

Serial-to-parallel receiver: the far-end counterpart of the team's 8-bit parallel-load serializer. Samples one bit per qualified clock on `sin`, assembles LSB-first frames, and presents each completed word on a valid/ready holding register with a sticky overrun flag. It sits at the input of a datapath fed by the serializer's `y` output, sharing its clock.

## Interface
- `W`, default 8: data word width in bits; legal range 2..32.
- `clk` in 1: rising-edge clock, shared with the transmitting serializer.
- `reset_n` in 1: asynchronous, active-low reset; clears all state.
- `sin` in 1: serial data bit.
- `sin_en` in 1: bit qualifier; `sin` is sampled only on cycles with `sin_en`=1. Tie high for a bit-per-cycle link.
- `out_data` out W: last completed word; bit 0 = first bit received.
- `out_valid` out 1: holding register contains an unconsumed word.
- `out_ready` in 1: consumer accepts `out_data` on a cycle where `out_valid`=1.
- `overrun` out 1: sticky; a word completed while an older word was still held unconsumed.
- `clr_ovr` in 1: synchronous clear of `overrun`.
- `parity_err` out 1: parity result of the word in `out_data` (see Configuration).

## Operation
- Frame length F = W (W+1 with parity). A bit counter counts qualified bits 0..F-1 and wraps to 0 after F-1. `sin_en`=0 freezes counter and shift register.
- Shift register shifts right, inserting `sin` at the MSB; after W data bits, bit 0 holds the first bit received.
- Frame alignment is defined solely by reset: the first qualified bit after `reset_n` deasserts is bit 0. No resynchronisation mechanism exists.
- Completion occurs on the cycle the final bit of the frame is sampled. On completion the holding register loads the word from the shift register plus the incoming bit. No idle cycle exists between frames.
- Holding register states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY + completion: load, go FULL.
  - FULL + `out_ready`, no completion: go EMPTY.
  - FULL + `out_ready` + completion: load, stay FULL, no overrun.
  - FULL + no `out_ready` + completion: overwrite with new word, stay FULL, set `overrun`.
- `overrun` set and `clr_ovr` on the same cycle: set wins.
- Reset values: `out_data`=0, `out_valid`=0, `overrun`=0, `parity_err`=0, bit counter=0, shift register=0.
- Reset asserted mid-frame discards all partial bits. After release, the next qualified bit is bit 0.

## Timing
- Latency: the final bit is sampled at edge N; `out_valid` and `out_data` are updated at edge N. Data is visible from N until the next update.
- All outputs are registered. There is no combinational path from any input to any output.
- Sustained throughput is one word per F qualified cycles. With `out_ready` held high, overrun never occurs.

## Configuration
- `DESER_PARITY_EN` defined: F = W+1; the final bit is an even-parity bit over the W data bits. It is not stored in `out_data`. `parity_err` loads with each word: 1 if XOR of data bits and parity bit is 1.
- `DESER_PARITY_EN` undefined: F = W; `parity_err` is held at constant 0.

## Structure
- Package `deser_pkg` holds the default width constant `DESER_W_DEF`=8 and a function returning frame length F for a given W and parity setting.
- One sub-module, `deser_bit_counter`: modulo-F counter with enable and async active-low reset, emitting a `last` strobe when count = F-1 and enable is high.

## Test plan
- Reset, `sin_en`=1, `out_ready`=1, serialize 0xA5 LSB-first (1,0,1,0,0,1,0,1) -> `out_valid` high at the edge of the 8th bit, `out_data`=0xA5, `overrun`=0.
- Back-to-back 0x3C then 0xC3, `out_ready`=1 -> two consecutive 8-cycle frames, no gap, `out_data` 0x3C then 0xC3, `overrun` stays 0.
- `out_ready`=0, send 0x11 then 0x22 -> `out_data`=0x22, `overrun`=1. Pulse `clr_ovr` -> `overrun`=0, `out_valid` remains 1.
- `sin_en` toggled 1,0 every cycle while sending 0x5A -> same result as continuous: `out_data`=0x5A after 16 clocks.
- `reset_n` low after 4 bits of 0xFF, then send 0x0F -> `out_data`=0x0F; no residue from the partial frame.
- With `DESER_PARITY_EN`, send 0x03 with parity 0 -> `parity_err`=0; 0x03 with parity 1 -> `parity_err`=1.

Source files
------------

// File: rtl/deser_pkg.sv
// deser_pkg: shared constants and helpers for the deser_rx receiver.
//   DESER_W_DEF - default data word width
//   frame_len() - number of qualified bits per frame for a given width
//                 and parity setting
package deser_pkg;

  localparam int DESER_W_DEF = 8;

  // One extra bit per frame when a parity bit trails the data bits
  function automatic int frame_len(input int w, input bit parity_en);
    return parity_en ? w + 1 : w;
  endfunction

endpackage

// File: rtl/deser_if.sv
// deser_if: bundles the serial input and the parallel valid/ready output
// of deser_rx.
//   master modport - the receiver: takes sin/sin_en/out_ready/clr_ovr,
//                    drives out_data/out_valid/overrun/parity_err
//   slave modport  - the environment feeding bits and consuming words
interface deser_if
  import deser_pkg::*;
#(
  parameter int W = DESER_W_DEF
);

  logic         sin;
  logic         sin_en;
  logic         out_ready;
  logic         clr_ovr;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         overrun;
  logic         parity_err;

  modport master (
    input  sin, sin_en, out_ready, clr_ovr,
    output out_data, out_valid, overrun, parity_err
  );

  modport slave (
    output sin, sin_en, out_ready, clr_ovr,
    input  out_data, out_valid, overrun, parity_err
  );

endinterface

// File: rtl/deser_bit_counter.sv
// deser_bit_counter: modulo-F counter of qualified serial bits.
//   clk, reset_n - clock and asynchronous active-low reset
//   en           - count enable (one qualified bit)
//   last         - high when the count is F-1 and en is high, i.e. the
//                  bit being sampled this cycle closes the frame
module deser_bit_counter #(
  parameter int F = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic last
);

  localparam int CW = (F > 1) ? $clog2(F) : 1;

  logic [CW-1:0] count;

  assign last = en && (count == CW'(F - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/deser_rx.sv
// deser_rx: serial-to-parallel receiver. Assembles LSB-first frames from
// qualified bits and presents each word in a valid/ready holding register
// with a sticky overrun flag.
//   clk, reset_n - clock and asynchronous active-low reset
//   bus          - deser_if master: sin/sin_en in, out_data/out_valid/
//                  out_ready handshake, overrun/clr_ovr, parity_err
// Optional feature: define DESER_PARITY_EN for a trailing even-parity bit
// per frame; otherwise parity_err is constant 0.
module deser_rx
  import deser_pkg::*;
#(
  parameter int W = DESER_W_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  deser_if.master  bus
);

`ifdef DESER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int F = frame_len(W, PARITY_EN);

  logic [W-1:0] shreg;
  logic [W-1:0] word;
  logic         last;

  deser_bit_counter #(.F(F)) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.sin_en),
    .last    (last)
  );

  // Right shift with new bit at the MSB, so after W data bits the first
  // bit received sits in bit 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (bus.sin_en) begin
      shreg <= {bus.sin, shreg[W-1:1]};
    end
  end

`ifdef DESER_PARITY_EN
  // The closing bit is parity, so the data is already fully in shreg
  assign word = shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.parity_err <= 1'b0;
    end else if (last) begin
      bus.parity_err <= ^{shreg, bus.sin};
    end
  end
`else
  // The closing bit is the last data bit and has not been shifted in yet
  assign word = {bus.sin, shreg[W-1:1]};
  assign bus.parity_err = 1'b0;
`endif

  // Holding register: a completed word always loads, even over an
  // unconsumed one; consumption only empties it when nothing new arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else if (last) begin
      bus.out_data  <= word;
      bus.out_valid <= 1'b1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new overrun takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.overrun <= 1'b0;
    end else if (last && bus.out_valid && !bus.out_ready) begin
      bus.overrun <= 1'b1;
    end else if (bus.clr_ovr) begin
      bus.overrun <= 1'b0;
    end
  end

endmodule
